// File: rtl/t2mi_timestamp_extractor.sv
// T2-MI timestamp extractor: picks type-0x20 packets out of the parser byte
// stream, assembles bw/seconds/subseconds/utco and publishes one per packet.
//
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   packet_*       parser byte stream (start pulse, type, length, bytes, end)
//   ts_valid       1-cycle pulse, ts_* fields updated this cycle
//   ts_bw/seconds/subseconds/utco  last accepted timestamp
//   ts_error       1-cycle pulse, a timestamp packet was rejected
//   ts_count/err_count  saturating accept / reject counters
module t2mi_timestamp_extractor #(
   parameter logic [7:0] TS_PACKET_TYPE   = 8'h20,
   parameter int         TS_PAYLOAD_BYTES = 11,
   parameter int         CNT_WIDTH        = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 packet_start,
   input  logic [7:0]           packet_type,
   input  logic [15:0]          packet_length,
   input  logic                 packet_valid,
   input  logic [7:0]           packet_data,
   input  logic                 packet_end,
   output logic                 ts_valid,
   output logic [3:0]           ts_bw,
   output logic [39:0]          ts_seconds,
   output logic [26:0]          ts_subseconds,
   output logic [12:0]          ts_utco,
   output logic                 ts_error,
   output logic [CNT_WIDTH-1:0] ts_count,
   output logic [CNT_WIDTH-1:0] err_count
);

   typedef enum logic [1:0] {IDLE, FIRST, COLLECT, SKIP} state_t;

   localparam logic [3:0]  NB  = 4'(TS_PAYLOAD_BYTES);
   localparam logic [15:0] NBL = 16'(TS_PAYLOAD_BYTES);

   state_t         state_q, state_d;
   logic [3:0]     idx_q, idx_d, idx_n;
   logic [79:0]    sr_q, sr_d, sr_n;
   logic [3:0]     b0_q, b0_d;
   logic           acc, rej;
   logic           last;

   logic                 vld_q, err_q;
   logic [3:0]           bw_q;
   logic [39:0]          sec_q;
   logic [26:0]          sub_q;
   logic [12:0]          utc_q;
   logic [CNT_WIDTH-1:0] tcnt_q, ecnt_q;

   assign last = packet_valid & packet_end;

   // Byte-accepted view of idx / shift register, used by COLLECT.
   always_comb begin
      idx_n = idx_q;
      sr_n  = sr_q;
      if (idx_q < NB) begin
         idx_n = idx_q + 4'd1;
         sr_n  = {sr_q[71:0], packet_data};
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      sr_d    = sr_q;
      b0_d    = b0_q;
      acc     = 1'b0;
      rej     = 1'b0;
      unique case (state_q)
         IDLE: ;
         FIRST: begin
            if (packet_valid) begin
               if (packet_type != TS_PACKET_TYPE) begin
                  state_d = packet_end ? IDLE : SKIP;
               end else begin
                  b0_d    = packet_data[3:0];
                  idx_d   = 4'd1;
                  state_d = COLLECT;
                  if (packet_end) begin
                     rej     = 1'b1;
                     state_d = IDLE;
                  end
               end
            end
         end
         COLLECT: begin
            if (packet_valid) begin
               idx_d = idx_n;
               sr_d  = sr_n;
            end
            if (last) begin
               state_d = IDLE;
               if (idx_n == NB && packet_length >= NBL) acc = 1'b1;
               else                                    rej = 1'b1;
            end else if (packet_start) begin
               // New packet before this one ended: abandoned timestamp.
               rej = 1'b1;
            end
         end
         SKIP: if (last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // A start always opens a new packet; any end in the same cycle
      // has already been decided above.
      if (packet_start) state_d = FIRST;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         sr_q    <= '0;
         b0_q    <= '0;
         vld_q   <= 1'b0;
         err_q   <= 1'b0;
         bw_q    <= '0;
         sec_q   <= '0;
         sub_q   <= '0;
         utc_q   <= '0;
         tcnt_q  <= '0;
         ecnt_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         sr_q    <= sr_d;
         b0_q    <= b0_d;
         vld_q   <= acc;
         err_q   <= rej;
         if (acc) begin
            bw_q  <= b0_q;
            sec_q <= sr_d[79:40];
            sub_q <= sr_d[39:13];
            utc_q <= sr_d[12:0];
            if (tcnt_q != '1) tcnt_q <= tcnt_q + 1'b1;
         end
         if (rej && ecnt_q != '1) ecnt_q <= ecnt_q + 1'b1;
      end
   end

   assign ts_valid      = vld_q;
   assign ts_error      = err_q;
   assign ts_bw         = bw_q;
   assign ts_seconds    = sec_q;
   assign ts_subseconds = sub_q;
   assign ts_utco       = utc_q;
   assign ts_count      = tcnt_q;
   assign err_count     = ecnt_q;

endmodule

// File: tb/tb_t2mi_timestamp_extractor.sv
// Directed bench for t2mi_timestamp_extractor.
// Inputs change on negedge, outputs are sampled on negedge.
module tb_t2mi_timestamp_extractor;

   logic        clk = 1'b0;
   logic        rst;
   logic        packet_start;
   logic [7:0]  packet_type;
   logic [15:0] packet_length;
   logic        packet_valid;
   logic [7:0]  packet_data;
   logic        packet_end;
   logic        ts_valid;
   logic [3:0]  ts_bw;
   logic [39:0] ts_seconds;
   logic [26:0] ts_subseconds;
   logic [12:0] ts_utco;
   logic        ts_error;
   logic [15:0] ts_count;
   logic [15:0] err_count;

   int nvec = 0;
   int nerr = 0;
   logic [7:0] pay [0:31];

   always #5 clk = ~clk;

   t2mi_timestamp_extractor dut (
      .clk(clk), .rst(rst),
      .packet_start(packet_start), .packet_type(packet_type),
      .packet_length(packet_length), .packet_valid(packet_valid),
      .packet_data(packet_data), .packet_end(packet_end),
      .ts_valid(ts_valid), .ts_bw(ts_bw), .ts_seconds(ts_seconds),
      .ts_subseconds(ts_subseconds), .ts_utco(ts_utco),
      .ts_error(ts_error), .ts_count(ts_count), .err_count(err_count)
   );

   task automatic load_good();
      logic [7:0] g [0:10];
      g = '{8'h05, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78,
            8'h00, 8'h00, 8'h00, 8'h40, 8'h0A};
      for (int i = 0; i < 32; i++) pay[i] = (i < 11) ? g[i] : 8'hFF;
   endtask

   // Stimulus only: optional start pulse, then n bytes (end on last if e).
   // Returns on the negedge where a registered pulse is visible.
   task automatic send_pkt(input logic [7:0] typ, input logic [15:0] len,
                           input int n, input bit e, input bit st);
      if (st) begin
         @(negedge clk);
         packet_start = 1'b1;
         @(negedge clk);
         packet_start = 1'b0;
      end
      packet_type   = typ;
      packet_length = len;
      for (int i = 0; i < n; i++) begin
         packet_valid = 1'b1;
         packet_data  = pay[i];
         packet_end   = e && (i == n - 1);
         @(negedge clk);
      end
      packet_valid = 1'b0;
      packet_end   = 1'b0;
   endtask

   task automatic chk(input string nm, input logic [39:0] got,
                      input logic [39:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      nvec++;
      if ({ts_valid, ts_error, ts_bw, ts_seconds, ts_subseconds, ts_utco,
           ts_count, err_count} !== '0) begin
         nerr++;
         $display("FAIL reset outputs got %0h expected 0",
                  {ts_valid, ts_error, ts_seconds, ts_count, err_count});
      end
   endtask

   task automatic test_basic();
      load_good();
      send_pkt(8'h20, 16'd11, 11, 1'b1, 1'b1);
      chk("basic_valid", 40'(ts_valid), 40'd1);
      chk("basic_bw", 40'(ts_bw), 40'd5);
      chk("basic_sec", ts_seconds, 40'h0012345678);
      chk("basic_sub", 40'(ts_subseconds), 40'h2);
      chk("basic_utco", 40'(ts_utco), 40'h000A);
      chk("basic_cnt", 40'(ts_count), 40'd1);
      @(negedge clk);
      chk("basic_pulse_1cyc", 40'(ts_valid), 40'd0);
   endtask

   task automatic test_long();
      load_good();
      send_pkt(8'h20, 16'd14, 14, 1'b1, 1'b1);
      chk("long_valid", 40'(ts_valid), 40'd1);
      chk("long_sec", ts_seconds, 40'h0012345678);
      chk("long_utco", 40'(ts_utco), 40'h000A);
      chk("long_cnt", 40'(ts_count), 40'd2);
   endtask

   task automatic test_short();
      for (int i = 0; i < 8; i++) pay[i] = 8'h99;
      send_pkt(8'h20, 16'd8, 8, 1'b1, 1'b1);
      chk("short_err", 40'(ts_error), 40'd1);
      chk("short_valid", 40'(ts_valid), 40'd0);
      chk("short_errcnt", 40'(err_count), 40'd1);
      chk("short_sec_hold", ts_seconds, 40'h0012345678);
      chk("short_bw_hold", 40'(ts_bw), 40'd5);
   endtask

   task automatic test_other_type();
      load_good();
      send_pkt(8'h10, 16'd20, 20, 1'b1, 1'b1);
      chk("other_nopulse", 40'({ts_valid, ts_error}), 40'd0);
      send_pkt(8'h20, 16'd11, 11, 1'b1, 1'b1);
      chk("other_then_valid", 40'(ts_valid), 40'd1);
      chk("other_cnt", 40'(ts_count), 40'd3);
   endtask

   task automatic test_abort();
      load_good();
      send_pkt(8'h20, 16'd11, 6, 1'b0, 1'b1);
      packet_start = 1'b1;
      @(negedge clk);
      packet_start = 1'b0;
      chk("abort_err", 40'(ts_error), 40'd1);
      chk("abort_errcnt", 40'(err_count), 40'd2);
      send_pkt(8'h20, 16'd11, 11, 1'b1, 1'b0);
      chk("abort_next_valid", 40'(ts_valid), 40'd1);
      chk("abort_cnt", 40'(ts_count), 40'd4);
   endtask

   task automatic test_back_to_back();
      load_good();
      send_pkt(8'h20, 16'd11, 10, 1'b0, 1'b1);
      packet_valid = 1'b1;
      packet_data  = pay[10];
      packet_end   = 1'b1;
      packet_start = 1'b1;
      @(negedge clk);
      packet_valid = 1'b0;
      packet_end   = 1'b0;
      packet_start = 1'b0;
      chk("b2b_first_valid", 40'(ts_valid), 40'd1);
      chk("b2b_first_cnt", 40'(ts_count), 40'd5);
      pay[0] = 8'h03;
      pay[5] = 8'h79;
      send_pkt(8'h20, 16'd11, 11, 1'b1, 1'b0);
      chk("b2b_second_valid", 40'(ts_valid), 40'd1);
      chk("b2b_second_bw", 40'(ts_bw), 40'd3);
      chk("b2b_second_sec", ts_seconds, 40'h0012345679);
      chk("b2b_second_cnt", 40'(ts_count), 40'd6);
      chk("b2b_errcnt", 40'(err_count), 40'd2);
   endtask

   task automatic test_reset_mid();
      load_good();
      send_pkt(8'h20, 16'd11, 5, 1'b0, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rstmid_err", 40'(ts_error), 40'd0);
      chk("rstmid_cnt", 40'(ts_count), 40'd0);
      chk("rstmid_errcnt", 40'(err_count), 40'd0);
      chk("rstmid_sec", ts_seconds, 40'd0);
      send_pkt(8'h20, 16'd11, 11, 1'b1, 1'b1);
      chk("rstmid_next_valid", 40'(ts_valid), 40'd1);
      chk("rstmid_next_cnt", 40'(ts_count), 40'd1);
      chk("rstmid_next_sub", 40'(ts_subseconds), 40'h2);
   endtask

   initial begin
      rst           = 1'b1;
      packet_start  = 1'b0;
      packet_type   = 8'h00;
      packet_length = 16'd0;
      packet_valid  = 1'b0;
      packet_data   = 8'h00;
      packet_end    = 1'b0;
      test_reset();
      test_basic();
      test_long();
      test_short();
      test_other_type();
      test_abort();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
